vga_sync_decoder: RTL and testbench

Receive-side counterpart of the 640x480@60Hz VGA timing generator. Monitors an incoming active-low h_sync/v_sync pair in the pixel-clock domain and rebuilds the pixel coordinates and display-enable from the sync edges alone. Measures line and frame lengths, flags timing violations and reports lock. Used by capture/overlay logic that must align to an externally generated VGA stream.

---
 rtl/vga_sync_decoder.sv | 251 +++++++++++++++++++++++++
 tb/tb_vga_sync_decoder.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder
//   Rebuilds pixel coordinates and display-enable from an incoming
//   active-low VGA h_sync/v_sync pair, measures line and frame lengths,
//   flags timing violations and reports lock once consecutive frames
//   match the expected geometry.
//
// Ports:
//   clk          pixel clock
//   reset        synchronous, active-high
//   h_sync_in    incoming horizontal sync, active-low, synchronous to clk
//   v_sync_in    incoming vertical sync, active-low, synchronous to clk
//   x, y         recovered column / line
//   video_on     high inside the visible region while locked
//   locked       timing verified
//   h_err        1-cycle pulse on a bad line length or hsync loss
//   v_err        1-cycle pulse on a bad frame length
//   line_len     clocks between the last two hsync falls
//   frame_lines  hsync falls between the last two vsync falls
module vga_sync_decoder #(
  parameter int H_DISPLAY   = 640,
  parameter int H_FRONT     = 16,
  parameter int H_TOTAL     = 800,
  parameter int V_DISPLAY   = 480,
  parameter int V_FRONT     = 10,
  parameter int V_TOTAL     = 525,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        h_sync_in,
  input  logic        v_sync_in,
  output logic [9:0]  x,
  output logic [9:0]  y,
  output logic        video_on,
  output logic        locked,
  output logic        h_err,
  output logic        v_err,
  output logic [10:0] line_len,
  output logic [9:0]  frame_lines
);

  localparam logic [9:0]  X_VIS      = 10'(H_DISPLAY);
  localparam logic [9:0]  X_ALIGN    = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0]  X_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0]  Y_VIS      = 10'(V_DISPLAY);
  localparam logic [9:0]  Y_ALIGN    = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0]  Y_LAST     = 10'(V_TOTAL - 1);
  localparam logic [10:0] HP_NOMINAL = 11'(H_TOTAL);
  // Loss is flagged on the edge where hp steps onto 2*H_TOTAL.
  localparam logic [10:0] HP_LOSS_M1 = 11'(2 * H_TOTAL - 1);
  localparam logic [10:0] HP_MAX     = 11'h7FF;
  localparam logic [9:0]  LC_NOMINAL = 10'(V_TOTAL);
  localparam logic [9:0]  LC_MAX     = 10'h3FF;
  localparam int          GW         = (LOCK_FRAMES < 2) ? 1 : $clog2(LOCK_FRAMES + 1);
  localparam logic [GW-1:0] GOOD_LOCK = GW'(LOCK_FRAMES);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          h_q, h_d;
  logic          v_q, v_d;
  logic [9:0]    x_q, x_d;
  logic [9:0]    y_q, y_d;
  logic [10:0]   hp_q, hp_d;
  logic [9:0]    lc_q, lc_d;
  logic [10:0]   line_len_q, line_len_d;
  logic [9:0]    frame_lines_q, frame_lines_d;
  logic          h_err_q, h_err_d;
  logic          v_err_q, v_err_d;
  logic          video_on_q, video_on_d;
  logic          locked_q, locked_d;
  logic [GW-1:0] good_q, good_d;
  logic          frame_bad_q, frame_bad_d;
  logic          seen_h_q, seen_h_d;     // an hfall has been measured since reset/SEARCH entry
  logic          seen_v_q, seen_v_d;     // a vfall has been measured since reset/SEARCH entry
  logic          hloss_done_q, hloss_done_d;

  logic          hfall, vfall, x_wrap, line_bad, hloss, frame_good;
  logic [GW-1:0] good_inc;

  always_comb begin
    hfall         = ~h_sync_in & h_q;
    vfall         = ~v_sync_in & v_q;
    h_d           = h_sync_in;
    v_d           = v_sync_in;
    x_d           = x_q;
    y_d           = y_q;
    hp_d          = hp_q;
    lc_d          = lc_q;
    line_len_d    = line_len_q;
    frame_lines_d = frame_lines_q;
    seen_h_d      = seen_h_q;
    seen_v_d      = seen_v_q;
    hloss_done_d  = hloss_done_q;
    frame_bad_d   = frame_bad_q;
    state_d       = state_q;
    good_d        = good_q;
    x_wrap        = 1'b0;
    line_bad      = 1'b0;
    hloss         = 1'b0;
    v_err_d       = 1'b0;
    good_inc      = good_q + GW'(1);

    // Column: snap to the sync position on hfall, otherwise free-run.
    if (hfall) begin
      x_d = X_ALIGN;
    end else if (x_q == X_LAST) begin
      x_d    = 10'd0;
      x_wrap = 1'b1;
    end else begin
      x_d = x_q + 10'd1;
    end

    // Line: vfall realignment takes priority over a coincident wrap.
    if (vfall) begin
      y_d = Y_ALIGN;
    end else if (x_wrap) begin
      y_d = (y_q == Y_LAST) ? 10'd0 : y_q + 10'd1;
    end

    // Line period measurement and hsync loss detection.
    if (hfall) begin
      hp_d         = 11'd1;
      line_len_d   = hp_q;
      line_bad     = seen_h_q && (hp_q != HP_NOMINAL);
      seen_h_d     = 1'b1;
      hloss_done_d = 1'b0;
    end else begin
      if (hp_q != HP_MAX) begin
        hp_d = hp_q + 11'd1;
      end
      if ((hp_q == HP_LOSS_M1) && !hloss_done_q) begin
        hloss        = 1'b1;
        hloss_done_d = 1'b1;
      end
    end
    h_err_d = line_bad | hloss;

    // Frame length: an hfall coincident with vfall belongs to the new frame.
    frame_good = !(frame_bad_q || h_err_d) && (lc_q == LC_NOMINAL);
    if (vfall) begin
      lc_d          = hfall ? 10'd1 : 10'd0;
      frame_lines_d = lc_q;
      v_err_d       = seen_v_q && (lc_q != LC_NOMINAL);
      seen_v_d      = 1'b1;
      frame_bad_d   = 1'b0;
    end else begin
      if (hfall && (lc_q != LC_MAX)) begin
        lc_d = lc_q + 10'd1;
      end
      if (h_err_d) begin
        frame_bad_d = 1'b1;
      end
    end

    // Lock state machine.
    case (state_q)
      SEARCH: begin
        if (vfall) begin
          state_d = VERIFY;
          good_d  = '0;
        end
      end
      VERIFY: begin
        if (hloss) begin
          state_d = SEARCH;
        end else if (vfall) begin
          if (frame_good) begin
            good_d = good_inc;
            if (good_inc == GOOD_LOCK) begin
              state_d = LOCKED;
            end
          end else begin
            good_d = '0;
          end
        end
      end
      LOCKED: begin
        if (h_err_d || v_err_d) begin
          state_d = SEARCH;
        end
      end
      default: state_d = SEARCH;
    endcase

    // Entering SEARCH restarts measurement so the first edges are not judged.
    if ((state_d == SEARCH) && (state_q != SEARCH)) begin
      seen_h_d = 1'b0;
      seen_v_d = 1'b0;
    end

    locked_d   = (state_d == LOCKED);
    video_on_d = (x_d < X_VIS) && (y_d < Y_VIS) && locked_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= SEARCH;
      h_q           <= 1'b1;
      v_q           <= 1'b1;
      x_q           <= '0;
      y_q           <= '0;
      hp_q          <= '0;
      lc_q          <= '0;
      line_len_q    <= '0;
      frame_lines_q <= '0;
      h_err_q       <= 1'b0;
      v_err_q       <= 1'b0;
      video_on_q    <= 1'b0;
      locked_q      <= 1'b0;
      good_q        <= '0;
      frame_bad_q   <= 1'b0;
      seen_h_q      <= 1'b0;
      seen_v_q      <= 1'b0;
      hloss_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      h_q           <= h_d;
      v_q           <= v_d;
      x_q           <= x_d;
      y_q           <= y_d;
      hp_q          <= hp_d;
      lc_q          <= lc_d;
      line_len_q    <= line_len_d;
      frame_lines_q <= frame_lines_d;
      h_err_q       <= h_err_d;
      v_err_q       <= v_err_d;
      video_on_q    <= video_on_d;
      locked_q      <= locked_d;
      good_q        <= good_d;
      frame_bad_q   <= frame_bad_d;
      seen_h_q      <= seen_h_d;
      seen_v_q      <= seen_v_d;
      hloss_done_q  <= hloss_done_d;
    end
  end

  assign x           = x_q;
  assign y           = y_q;
  assign video_on    = video_on_q;
  assign locked      = locked_q;
  assign h_err       = h_err_q;
  assign v_err       = v_err_q;
  assign line_len    = line_len_q;
  assign frame_lines = frame_lines_q;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// tb_vga_sync_decoder
//   Drives a scaled-down VGA sync stream (with stretched lines, short frames,
//   hsync dropouts, mid-frame reset and random noise) into vga_sync_decoder.
//   A timestamp-based reference model pushes the expected outputs of every
//   clock into a queue; a monitor pops and compares on the falling edge.
module tb_vga_sync_decoder;

  localparam int HD    = 16;
  localparam int HF    = 4;
  localparam int HT    = 24;
  localparam int VD    = 8;
  localparam int VF    = 2;
  localparam int VT    = 12;
  localparam int LF    = 2;
  localparam int FRAME = HT * VT;

  logic        clk;
  logic        reset;
  logic        h_sync_in;
  logic        v_sync_in;
  logic [9:0]  x;
  logic [9:0]  y;
  logic        video_on;
  logic        locked;
  logic        h_err;
  logic        v_err;
  logic [10:0] line_len;
  logic [9:0]  frame_lines;

  vga_sync_decoder #(
    .H_DISPLAY(HD), .H_FRONT(HF), .H_TOTAL(HT),
    .V_DISPLAY(VD), .V_FRONT(VF), .V_TOTAL(VT),
    .LOCK_FRAMES(LF)
  ) dut (
    .clk(clk), .reset(reset),
    .h_sync_in(h_sync_in), .v_sync_in(v_sync_in),
    .x(x), .y(y), .video_on(video_on), .locked(locked),
    .h_err(h_err), .v_err(v_err),
    .line_len(line_len), .frame_lines(frame_lines)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int x;
    int y;
    bit vo;
    bit lk;
    bit he;
    bit ve;
    int ll;
    int fl;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  // ---------------- reference model (timestamp based) ----------------
  int m_e = 0;                      // edge index
  int h_anchor, x_anchor_e, x_anchor_val;
  int m_y, lines, good, mode;       // mode: 0 search, 1 verify, 2 locked
  int m_ll, m_fl;
  bit prev_h, prev_v, seen_h, seen_v, frame_err, loss_rep;

  task automatic model_edge(input bit h, input bit v, input bit r);
    exp_t e;
    int   hp, xv;
    bit   hf, vf, he, ve, loss, fgood;
    m_e++;
    if (r) begin
      prev_h = 1; prev_v = 1;
      h_anchor = m_e + 1; x_anchor_e = m_e; x_anchor_val = 0;
      m_y = 0; lines = 0; good = 0; mode = 0; m_ll = 0; m_fl = 0;
      seen_h = 0; seen_v = 0; frame_err = 0; loss_rep = 0;
      e = '{x:0, y:0, vo:0, lk:0, he:0, ve:0, ll:0, fl:0};
      exp_q.push_back(e);
      return;
    end
    hf = prev_h && !h;
    vf = prev_v && !v;
    prev_h = h;
    prev_v = v;
    // Clocks since the last hsync fall (or since reset), saturating.
    hp = m_e - h_anchor;
    if (hp > 2047) hp = 2047;
    he = 0; loss = 0;
    if (hf) begin
      m_ll = hp;
      he = seen_h && (hp != HT);
      seen_h = 1; h_anchor = m_e; loss_rep = 0;
      x_anchor_e = m_e; x_anchor_val = HD + HF;
    end else if ((hp + 1 == 2 * HT) && !loss_rep) begin
      he = 1; loss = 1; loss_rep = 1;
    end
    xv = (x_anchor_val + (m_e - x_anchor_e)) % HT;
    if (vf) m_y = VD + VF;
    else if (!hf && xv == 0) m_y = (m_y + 1) % VT;
    ve = 0; fgood = 0;
    if (vf) begin
      m_fl = lines;
      ve = seen_v && (lines != VT);
      fgood = !(frame_err || he) && (lines == VT);
      seen_v = 1;
      lines = hf ? 1 : 0;
      frame_err = 0;
    end else begin
      if (hf && lines < 1023) lines++;
      if (he) frame_err = 1;
    end
    if (mode == 0) begin
      if (vf) begin mode = 1; good = 0; end
    end else if (mode == 1) begin
      if (loss) begin mode = 0; seen_h = 0; seen_v = 0; end
      else if (vf) begin
        if (fgood) begin
          good++;
          if (good == LF) mode = 2;
        end else good = 0;
      end
    end else if (he || ve) begin
      mode = 0; seen_h = 0; seen_v = 0;
    end
    e.x  = xv;
    e.y  = m_y;
    e.lk = (mode == 2);
    e.vo = (xv < HD) && (m_y < VD) && (mode == 2);
    e.he = he;
    e.ve = ve;
    e.ll = m_ll;
    e.fl = m_fl;
    exp_q.push_back(e);
  endtask

  // ---------------- monitor ----------------
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        tests++;
        if (int'(x) != e.x || int'(y) != e.y || video_on !== e.vo || locked !== e.lk ||
            h_err !== e.he || v_err !== e.ve || int'(line_len) != e.ll || int'(frame_lines) != e.fl) begin
          fails++;
          $display("FAIL outputs at %0t: got x=%0d y=%0d vo=%0b lk=%0b he=%0b ve=%0b ll=%0d fl=%0d, expected x=%0d y=%0d vo=%0b lk=%0b he=%0b ve=%0b ll=%0d fl=%0d",
                   $time, x, y, video_on, locked, h_err, v_err, line_len, frame_lines,
                   e.x, e.y, e.vo, e.lk, e.he, e.ve, e.ll, e.fl);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  int herr_cnt, verr_cnt, vo_cnt;
  int last_err_ll, last_err_lk, last_verr_fl, last_verr_lk;
  int gx, gy, line_total, frame_total, hw;
  bit stretch_req, short_req, hold_h;

  task automatic check(input string name, input int got, input int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  task automatic clear_counts();
    herr_cnt = 0; verr_cnt = 0; vo_cnt = 0;
    last_err_ll = -1; last_err_lk = -1; last_verr_fl = -1; last_verr_lk = -1;
  endtask

  task automatic step(input bit h, input bit v, input bit r);
    h_sync_in = h;
    v_sync_in = v;
    reset     = r;
    @(posedge clk);
    model_edge(h, v, r);
    #1;
    if (h_err) begin herr_cnt++; last_err_ll = int'(line_len); last_err_lk = int'(locked); end
    if (v_err) begin verr_cnt++; last_verr_fl = int'(frame_lines); last_verr_lk = int'(locked); end
    if (video_on) vo_cnt++;
  endtask

  task automatic gen_cycle(input bit r);
    bit h, v;
    h = !(gx >= HD + HF && gx < HD + HF + hw) || hold_h;
    v = !(gy >= VD + VF && gy < VD + VF + 2);
    step(h, v, r);
    if (gx >= line_total - 1) begin
      gx = 0;
      hw = $urandom_range(1, 4);
      line_total = stretch_req ? HT + 1 : HT;
      stretch_req = 0;
      if (gy >= frame_total - 1) begin
        gy = 0;
        frame_total = short_req ? VT - 1 : VT;
        short_req = 0;
      end else gy++;
    end else gx++;
  endtask

  initial begin
    reset = 1'b1; h_sync_in = 1'b1; v_sync_in = 1'b1;
    gx = 0; gy = 0; line_total = HT; frame_total = VT; hw = 4;
    stretch_req = 0; short_req = 0; hold_h = 0;
    clear_counts();
    repeat (3) step(1, 1, 1);

    // Nominal stream: lock after the third vsync fall.
    clear_counts();
    repeat (3 * FRAME + HT) gen_cycle(0);
    check("nominal locked", locked, 1);
    check("nominal h_err count", herr_cnt, 0);
    check("nominal v_err count", verr_cnt, 0);
    check("nominal line_len", line_len, HT);
    check("nominal frame_lines", frame_lines, VT);
    vo_cnt = 0;
    repeat (FRAME) gen_cycle(0);
    check("video_on cycles per frame", vo_cnt, HD * VD);
    $display("[TB] nominal stream: locked=%0b line_len=%0d frame_lines=%0d", locked, line_len, frame_lines);

    // One stretched line while locked.
    repeat ($urandom_range(0, FRAME - 1)) gen_cycle(0);
    clear_counts();
    stretch_req = 1;
    repeat (3 * HT + 2) gen_cycle(0);
    check("stretch h_err count", herr_cnt, 1);
    check("stretch line_len at error", last_err_ll, HT + 1);
    check("stretch locked at error", last_err_lk, 0);
    repeat (4 * FRAME) gen_cycle(0);
    check("stretch relocked", locked, 1);
    check("stretch total h_err", herr_cnt, 1);
    check("stretch v_err count", verr_cnt, 0);
    $display("[TB] stretched line: h_err pulses=%0d relocked=%0b", herr_cnt, locked);

    // One short frame while locked.
    clear_counts();
    short_req = 1;
    repeat (4 * FRAME) gen_cycle(0);
    check("short v_err count", verr_cnt, 1);
    check("short frame_lines at error", last_verr_fl, VT - 1);
    check("short locked at error", last_verr_lk, 0);
    check("short h_err count", herr_cnt, 0);
    check("frame_lines after short frame", frame_lines, VT);
    repeat (3 * FRAME) gen_cycle(0);
    check("short relocked", locked, 1);
    $display("[TB] short frame: v_err pulses=%0d relocked=%0b", verr_cnt, locked);

    // Hsync dropout.
    clear_counts();
    hold_h = 1;
    repeat ($urandom_range(2 * HT + 2, 2 * HT + 12)) gen_cycle(0);
    check("hold h_err count", herr_cnt, 1);
    check("hold locked", locked, 0);
    check("hold video_on", video_on, 0);
    hold_h = 0;
    repeat (HT) gen_cycle(0);
    check("hold h_err after restore", herr_cnt, 1);
    repeat (4 * FRAME) gen_cycle(0);
    check("hold relocked", locked, 1);
    $display("[TB] hsync dropout: h_err pulses=%0d relocked=%0b", herr_cnt, locked);

    // Reset mid-frame while locked.
    repeat ($urandom_range(1, FRAME)) gen_cycle(0);
    gen_cycle(1);
    check("reset x", x, 0);
    check("reset y", y, 0);
    check("reset video_on", video_on, 0);
    check("reset locked", locked, 0);
    check("reset h_err", h_err, 0);
    check("reset v_err", v_err, 0);
    check("reset line_len", line_len, 0);
    check("reset frame_lines", frame_lines, 0);
    repeat (4 * FRAME + HT) gen_cycle(0);
    check("reset relocked", locked, 1);
    $display("[TB] mid-frame reset: relocked=%0b", locked);

    // Random sync noise with occasional resets, then a clean frame.
    for (int i = 0; i < 300; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 15) != 0, $urandom_range(0, 63) == 0);
    end
    gen_cycle(1);
    repeat (FRAME) gen_cycle(0);
    $display("[TB] random noise segment done");

    @(negedge clk);
    @(negedge clk);
    check("scoreboard drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
